// File: rtl/sipo_deser_if.sv
// Word-side and serial-side signal bundle for sipo_deser.
// The slave modport is the deserialiser; master is the source/consumer side.
interface sipo_deser_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             din;
  logic             din_valid;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic [CW-1:0]    bit_cnt;
  logic             overrun;
  logic             parity_err;

  modport master (
    output din, din_valid, dout_ready,
    input  dout, dout_valid, bit_cnt, overrun, parity_err
  );

  modport slave (
    input  din, din_valid, dout_ready,
    output dout, dout_valid, bit_cnt, overrun, parity_err
  );
endinterface

// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserialiser with valid/ready word output and sticky overrun.
// Define SIPO_DESER_PARITY_EN to expect a trailing even-parity bit after each word.
module sipo_deser #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input logic         clk,
  input logic         clear,
  sipo_deser_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
`ifdef SIPO_DESER_PARITY_EN
  localparam int LAST = WIDTH;
`else
  localparam int LAST = WIDTH - 1;
`endif

  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] r_dout;
  logic [CW-1:0]    r_cnt;
  logic             r_valid;
  logic             r_ovr;

  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_word;
  logic             w_done;
  logic             w_data_bit;

  assign w_shift = (MSB_FIRST != 0) ? {r_sreg[WIDTH-2:0], bus.din}
                                    : {bus.din, r_sreg[WIDTH-1:1]};
  assign w_done  = bus.din_valid && (r_cnt == CW'(LAST));

`ifdef SIPO_DESER_PARITY_EN
  // The parity bit completes the word but never enters the shift register.
  assign w_data_bit = (r_cnt != CW'(WIDTH));
  assign w_word     = r_sreg;
`else
  assign w_data_bit = 1'b1;
  assign w_word     = w_shift;
`endif

  always_ff @(posedge clk) begin
    if (clear) begin
      r_sreg  <= '0;
      r_cnt   <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (bus.din_valid) begin
        if (w_data_bit) r_sreg <= w_shift;
        r_cnt <= w_done ? '0 : r_cnt + CW'(1);
      end
      // A completion wins over a same-edge handshake: the new word stays valid.
      if (w_done) begin
        r_dout  <= w_word;
        r_valid <= 1'b1;
        if (r_valid && !bus.dout_ready) r_ovr <= 1'b1;
      end else if (r_valid && bus.dout_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef SIPO_DESER_PARITY_EN
  logic r_perr;

  always_ff @(posedge clk) begin
    if (clear) r_perr <= 1'b0;
    else if (w_done) r_perr <= (^r_sreg) ^ bus.din;
  end

  assign bus.parity_err = r_perr;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_valid;
  assign bus.bit_cnt    = r_cnt;
  assign bus.overrun    = r_ovr;
endmodule

// File: tb/tb_sipo_deser.sv
// Scoreboard bench for sipo_deser: one MSB-first and one LSB-first instance share stimulus.
module tb_sipo_deser;
  logic clk = 1'b0;
  logic clear;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sipo_deser_if #(.WIDTH(8)) bus_a ();
  sipo_deser_if #(.WIDTH(8)) bus_b ();

  sipo_deser #(.WIDTH(8), .MSB_FIRST(1)) dut_msb (.clk(clk), .clear(clear), .bus(bus_a.slave));
  sipo_deser #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (.clk(clk), .clear(clear), .bus(bus_b.slave));

  typedef struct {
    int         due;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    logic       ovr;
    logic       perr;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic d, input logic v, input logic r);
    bus_a.din = d; bus_a.din_valid = v; bus_a.dout_ready = r;
    bus_b.din = d; bus_b.din_valid = v; bus_b.dout_ready = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, r);
      step();
    end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    step();
    clear = 1'b0;
  endtask

  // Sends w MSB first; gap inserts 3 idle cycles after the 4th bit.
  task automatic send_word(input logic [7:0] w, input logic [7:0] ea, input logic [7:0] eb,
                           input logic ovr, input logic pbit, input logic eperr,
                           input logic rdy_last, input logic gap);
    exp_t e;
    for (int i = 7; i >= 0; i--) begin
`ifdef SIPO_DESER_PARITY_EN
      drive(w[i], 1'b1, 1'b0);
`else
      drive(w[i], 1'b1, (i == 0) ? rdy_last : 1'b0);
`endif
      step();
      if (gap && i == 4) begin
        for (int g = 0; g < 3; g++) begin
          drive(1'b0, 1'b0, 1'b0);
          step();
          chk("gap_cnt_msb", 32'(bus_a.bit_cnt), 32'd4);
          chk("gap_cnt_lsb", 32'(bus_b.bit_cnt), 32'd4);
        end
      end
    end
`ifdef SIPO_DESER_PARITY_EN
    drive(pbit, 1'b1, rdy_last);
    step();
    e.perr = eperr;
`else
    e.perr = 1'b0;
`endif
    e.due   = cyc;
    e.exp_a = ea;
    e.exp_b = eb;
    e.ovr   = ovr;
    sb.push_back(e);
    drive(1'b0, 1'b0, 1'b0);
    chk("cnt_wrap_msb", 32'(bus_a.bit_cnt), 32'd0);
    chk("cnt_wrap_lsb", 32'(bus_b.bit_cnt), 32'd0);
  endtask

  // Monitor: compares the presented word on the cycle the scoreboard says it appears.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      if (sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        chk("valid_msb", 32'(bus_a.dout_valid), 32'd1);
        chk("valid_lsb", 32'(bus_b.dout_valid), 32'd1);
        chk("dout_msb", 32'(bus_a.dout), 32'(e.exp_a));
        chk("dout_lsb", 32'(bus_b.dout), 32'(e.exp_b));
        chk("ovr_msb", 32'(bus_a.overrun), 32'(e.ovr));
        chk("ovr_lsb", 32'(bus_b.overrun), 32'(e.ovr));
        chk("perr_msb", 32'(bus_a.parity_err), 32'(e.perr));
        chk("perr_lsb", 32'(bus_b.parity_err), 32'(e.perr));
      end else if (sb[0].due < cyc) begin
        chk("sb_missed", 32'(cyc), 32'(sb[0].due));
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    clear = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    step();
    step();
    clear = 1'b0;

    chk("rst_dout_msb", 32'(bus_a.dout), 32'd0);
    chk("rst_dout_lsb", 32'(bus_b.dout), 32'd0);
    chk("rst_valid", 32'({bus_a.dout_valid, bus_b.dout_valid}), 32'd0);
    chk("rst_cnt", 32'({bus_a.bit_cnt, bus_b.bit_cnt}), 32'd0);
    chk("rst_ovr", 32'({bus_a.overrun, bus_b.overrun}), 32'd0);
    chk("rst_perr", 32'({bus_a.parity_err, bus_b.parity_err}), 32'd0);

    // Basic word, consumed, then a ready pulse with nothing valid.
    send_word(8'hB2, 8'hB2, 8'h4D, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b1);
    chk("consume_valid_msb", 32'(bus_a.dout_valid), 32'd0);
    chk("consume_valid_lsb", 32'(bus_b.dout_valid), 32'd0);
    chk("consume_ovr", 32'({bus_a.overrun, bus_b.overrun}), 32'd0);
    idle(1, 1'b1);
    chk("idle_ready_valid", 32'({bus_a.dout_valid, bus_b.dout_valid}), 32'd0);
    chk("idle_ready_dout", 32'(bus_a.dout), 32'hB2);

    // Gapped word left unconsumed, then a second word overruns it.
    send_word(8'hB2, 8'hB2, 8'h4D, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);
    chk("held_dout_msb", 32'(bus_a.dout), 32'hB2);
    send_word(8'h0F, 8'h0F, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b1);
    chk("ovr_consume_valid", 32'({bus_a.dout_valid, bus_b.dout_valid}), 32'd0);
    chk("ovr_sticky_msb", 32'(bus_a.overrun), 32'd1);
    chk("ovr_sticky_lsb", 32'(bus_b.overrun), 32'd1);
    idle(3, 1'b0);
    chk("ovr_sticky_late", 32'({bus_a.overrun, bus_b.overrun}), 32'h3);

    // Completion and handshake on the same edge: no overrun.
    do_clear();
    chk("clr_ovr", 32'({bus_a.overrun, bus_b.overrun}), 32'd0);
    send_word(8'hC3, 8'hC3, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
    send_word(8'h5A, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1, 1'b0);
    chk("same_edge_valid", 32'({bus_a.dout_valid, bus_b.dout_valid}), 32'h3);
    chk("same_edge_ovr", 32'({bus_a.overrun, bus_b.overrun}), 32'd0);
    idle(1, 1'b1);
    chk("same_edge_consume", 32'({bus_a.dout_valid, bus_b.dout_valid}), 32'd0);

    // Clear mid-word discards the partial word.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      step();
    end
    chk("partial_cnt", 32'(bus_a.bit_cnt), 32'd5);
    do_clear();
    chk("clr_mid_cnt", 32'({bus_a.bit_cnt, bus_b.bit_cnt}), 32'd0);
    chk("clr_mid_valid", 32'({bus_a.dout_valid, bus_b.dout_valid}), 32'd0);
    send_word(8'hA5, 8'hA5, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b0);

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
